// File: rtl/spi_axis_reader.sv
// ---------------------------------------------------------------------------
// spi_axis_reader
//
// Purpose:
//   Configures a three-axis SPI sensor once after reset. It then reads the
//   six axis data bytes at a fixed period. The bytes are assembled into
//   signed 16-bit samples, and all three samples are presented together
//   with a one-cycle VALID strobe.
//
// Ports:
//   CLK       in   system clock, every register uses its rising edge
//   RST       in   asynchronous active-high reset
//   SPI_MISO  in   sensor serial data out
//   SPI_SCK   out  serial clock, SPI mode 3 (idles high)
//   SPI_MOSI  out  serial data to the sensor
//   SPI_CS_N  out  chip select, active low
//   OUT_X/Y/Z out  last complete axis samples, signed 16-bit
//   VALID     out  one-cycle pulse in the cycle OUT_X/Y/Z take new values
//   BUSY      out  high while SPI_CS_N is low
//
// Parameters:
//   CLK_DIV   CLK cycles per SCK half-period (2..255)
//   PERIOD    CLK cycles between read starts, CS_N fall to CS_N fall
//             (must exceed 120*CLK_DIV so that a read always fits)
// ---------------------------------------------------------------------------
module spi_axis_reader #(
  parameter int CLK_DIV = 6,
  parameter int PERIOD  = 120000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SPI_MISO,
  output logic               SPI_SCK,
  output logic               SPI_MOSI,
  output logic               SPI_CS_N,
  output logic signed [15:0] OUT_X,
  output logic signed [15:0] OUT_Y,
  output logic signed [15:0] OUT_Z,
  output logic               VALID,
  output logic               BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT,
    READ,
    UPDATE
  } state_t;

  // Phases of one transaction. LEAD is the single high stretch after CS_N
  // falls. LOW and HIGH repeat once per bit. The high phase of the last bit
  // doubles as the trailing SCK-high time before CS_N rises.
  typedef enum logic [1:0] {
    PH_LEAD,
    PH_LOW,
    PH_HIGH
  } phase_t;

  localparam int              PW         = $clog2(PERIOD);
  localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PER_LAST   = PW'(PERIOD - 1);

  // The configuration write sends register address 0x20 followed by 0x77.
  // The read sends the auto-increment read command 0xE8. It is followed by
  // zeros while the six data bytes are shifted in.
  localparam logic [15:0]     INIT_WORD  = 16'h2077;
  localparam logic [15:0]     READ_WORD  = 16'hE800;
  localparam logic [5:0]      INIT_LAST  = 6'd15;
  localparam logic [5:0]      READ_LAST  = 6'd55;

  state_t          state;
  state_t          state_next;

  logic            start_init;
  logic            start_read;
  logic            load_out;

  logic            xfer_active;
  phase_t          phase;
  logic [7:0]      div_cnt;
  logic [5:0]      bit_cnt;
  logic [5:0]      last_idx;
  logic [15:0]     tx_shift;
  logic [15:0]     tx_word;
  logic [47:0]     rx_shift;
  logic            xfer_end;

  logic [PW-1:0]   per_cnt;
  logic            per_run;
  logic            tick;
  logic            pending;

  // The last CLK cycle of a transaction: the final bit's high phase expires
  // here, and CS_N rises on the following edge.
  assign xfer_end = xfer_active && (phase == PH_HIGH) &&
                    (div_cnt == DIV_LAST) && (bit_cnt == last_idx);

  assign tx_word  = start_init ? INIT_WORD : READ_WORD;

  // The period counter only runs once configuration has finished. It is
  // held at zero through IDLE and INIT, so it reads 0 in the first WAIT
  // cycle.
  assign per_run  = (state != IDLE) && (state != INIT);
  assign tick     = per_run && (per_cnt == PER_LAST);

  assign BUSY     = ~SPI_CS_N;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. READ always finishes through UPDATE, so that the three
  // axis registers change together in one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = INIT;
      INIT:    if (xfer_end) state_next = WAIT;
      WAIT:    if (tick || pending) state_next = READ;
      READ:    if (xfer_end) state_next = UPDATE;
      UPDATE:  state_next = WAIT;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. The transaction starts are issued on the same edge as
  // the state change, so CS_N falls together with entry into INIT or READ.
  always_comb begin
    start_init = 1'b0;
    start_read = 1'b0;
    load_out   = 1'b0;
    VALID      = 1'b0;
    unique case (state)
      IDLE:    start_init = 1'b1;
      WAIT:    start_read = tick || pending;
      READ:    load_out   = xfer_end;
      UPDATE:  VALID      = 1'b1;
      default: ;
    endcase
  end

  // Free-running period counter. It wraps every PERIOD cycles. Because
  // the counter wraps on the same edge that starts a read, read starts
  // are exactly PERIOD cycles apart.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      per_cnt <= '0;
    end else if (!per_run) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // A tick that lands outside WAIT is remembered here until the block is
  // back in WAIT. A single flag means that at most one start is ever
  // owed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending <= 1'b0;
    end else if (start_read) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end
  end

  // SPI transaction engine.
  // - div_cnt times each half-period.
  // - MOSI moves only when SCK falls. The first bit is set up together
  //   with CS_N falling, so the first SCK fall leaves MOSI alone.
  // - MISO is captured on the edge that raises SCK. The read clocks 56 bits
  //   through a 48-bit register, so the command byte falls off the top and
  //   the six data bytes remain, with the first byte received in the top
  //   byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xfer_active <= 1'b0;
      SPI_CS_N    <= 1'b1;
      SPI_SCK     <= 1'b1;
      SPI_MOSI    <= 1'b0;
      phase       <= PH_LEAD;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      last_idx    <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
    end else if (start_init || start_read) begin
      xfer_active <= 1'b1;
      SPI_CS_N    <= 1'b0;
      SPI_SCK     <= 1'b1;
      SPI_MOSI    <= tx_word[15];
      tx_shift    <= {tx_word[14:0], 1'b0};
      phase       <= PH_LEAD;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      last_idx    <= start_init ? INIT_LAST : READ_LAST;
    end else if (xfer_active) begin
      if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        unique case (phase)
          PH_LEAD: begin
            SPI_SCK <= 1'b0;
            phase   <= PH_LOW;
          end
          PH_LOW: begin
            SPI_SCK  <= 1'b1;
            phase    <= PH_HIGH;
            rx_shift <= {rx_shift[46:0], SPI_MISO};
          end
          PH_HIGH: begin
            if (bit_cnt == last_idx) begin
              xfer_active <= 1'b0;
              SPI_CS_N    <= 1'b1;
              SPI_MOSI    <= 1'b0;
              phase       <= PH_LEAD;
              bit_cnt     <= '0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              SPI_SCK  <= 1'b0;
              SPI_MOSI <= tx_shift[15];
              tx_shift <= {tx_shift[14:0], 1'b0};
              phase    <= PH_LOW;
            end
          end
          default: phase <= PH_LEAD;
        endcase
      end
    end
  end

  // The axis registers load only on the last edge of a completed read, so
  // a half-received frame is never visible. Byte order on the wire is
  // XL, XH, YL, YH, ZL, ZH, and each sample is {H, L}.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_X <= '0;
      OUT_Y <= '0;
      OUT_Z <= '0;
    end else if (load_out) begin
      OUT_X <= {rx_shift[39:32], rx_shift[47:40]};
      OUT_Y <= {rx_shift[23:16], rx_shift[31:24]};
      OUT_Z <= {rx_shift[7:0],   rx_shift[15:8]};
    end
  end

endmodule

// File: tb/tb_spi_axis_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_axis_reader
//
// Purpose:
//   Directed bench for spi_axis_reader with CLK_DIV=2 and PERIOD=400.
//   - A mode-3 sensor model shifts a programmable six-byte frame out on
//     MISO.
//   - A cycle monitor records the length, SCK edge count and MOSI bits of
//     every completed transaction.
//   - The monitor also counts any cycle that breaks the pin-level
//     invariants.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_spi_axis_reader;

  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_miso = 1'b0;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [15:0] out_z;
  logic        valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  spi_axis_reader #(
    .CLK_DIV (CLK_DIV),
    .PERIOD  (PERIOD)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .SPI_MISO (spi_miso),
    .SPI_SCK  (spi_sck),
    .SPI_MOSI (spi_mosi),
    .SPI_CS_N (spi_cs_n),
    .OUT_X    (out_x),
    .OUT_Y    (out_y),
    .OUT_Z    (out_z),
    .VALID    (valid),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Sensor model. A new bit is presented on each SCK fall. The first eight
  // bit slots carry the command byte, so the frame starts at slot 8.
  logic [47:0] sensor_data = 48'h3412FFFF0080;
  int          fall_idx    = 0;

  always @(negedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      fall_idx = 0;
      spi_miso = 1'b0;
    end else begin
      if (fall_idx >= 8 && fall_idx < 56)
        spi_miso = sensor_data[47 - (fall_idx - 8)];
      else
        spi_miso = 1'b0;
      fall_idx++;
    end
  end

  // Cycle monitor. It samples on the falling CLK edge and records the
  // following:
  // - statistics for every transaction that completes normally;
  // - VALID pulses;
  // - CS_N fall times;
  // - invariant violations.
  int          cyc = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b1;
  logic        prev_mosi = 1'b0;
  logic [15:0] prev_x = '0;
  logic [15:0] prev_y = '0;
  logic [15:0] prev_z = '0;
  int          cur_len = 0;
  int          cur_rises = 0;
  logic [63:0] cur_mosi = '0;
  int          last_len = 0;
  int          last_rises = 0;
  logic [63:0] last_mosi = '0;
  int          txn_count = 0;
  int          valid_cnt = 0;
  int          valid_cyc = 0;
  int          rise_cyc = 0;
  int          last_fall = 0;
  int          prev_fall = 0;
  int          viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cur_len   = 0;
      cur_rises = 0;
      cur_mosi  = '0;
    end else begin
      if (spi_cs_n && !spi_sck) viol++;
      if (spi_cs_n && spi_mosi) viol++;
      if (busy !== !spi_cs_n) viol++;
      if (prev_sck && spi_sck && spi_mosi !== prev_mosi && spi_cs_n == prev_cs) viol++;
      if (spi_mosi !== prev_mosi && !(prev_sck && !spi_sck) && spi_cs_n == prev_cs) viol++;
      if ((out_x !== prev_x || out_y !== prev_y || out_z !== prev_z) && !valid) viol++;
      if (valid) begin
        valid_cnt++;
        valid_cyc = cyc;
      end
      if (prev_cs && !spi_cs_n) begin
        prev_fall = last_fall;
        last_fall = cyc;
        cur_len   = 0;
        cur_rises = 0;
        cur_mosi  = '0;
      end
      if (!spi_cs_n) begin
        cur_len++;
        if (!prev_sck && spi_sck) begin
          cur_rises++;
          cur_mosi = {cur_mosi[62:0], spi_mosi};
        end
      end
      if (!prev_cs && spi_cs_n) begin
        last_len   = cur_len;
        last_rises = cur_rises;
        last_mosi  = cur_mosi;
        rise_cyc   = cyc;
        txn_count++;
      end
    end
    prev_cs   = spi_cs_n;
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
    prev_x    = out_x;
    prev_y    = out_y;
    prev_z    = out_z;
  end

  // Waits a bounded number of cycles for the completed-transaction count
  // to reach target. Running out of cycles is recorded as a failed check.
  task automatic applyStimulus(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (txn_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 64'(txn_count >= target), 64'd1);
  endtask

  int saved_valid;
  int n_wait;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_sck",   spi_sck,  1'b1);
    checkOutput("rst_cs_n",  spi_cs_n, 1'b1);
    checkOutput("rst_mosi",  spi_mosi, 1'b0);
    checkOutput("rst_out_x", out_x,    16'h0000);
    checkOutput("rst_out_y", out_y,    16'h0000);
    checkOutput("rst_out_z", out_z,    16'h0000);
    checkOutput("rst_valid", valid,    1'b0);
    checkOutput("rst_busy",  busy,     1'b0);
    rst = 1'b0;

    // CS_N falls on the first edge after release.
    @(posedge clk);
    #1;
    checkOutput("init_cs_fall", spi_cs_n, 1'b0);
    checkOutput("init_busy",    busy,     1'b1);

    // Configuration write: 0x20, 0x77, 16 SCK rises, 33*CLK_DIV cycles.
    applyStimulus("init_done", 1, 200);
    checkOutput("init_len",   last_len,         66);
    checkOutput("init_rises", last_rises,       16);
    checkOutput("init_mosi",  last_mosi[15:0],  16'h2077);
    checkOutput("init_valid", valid_cnt,        0);

    // First read, with frame 34 12 FF FF 00 80.
    applyStimulus("read1_done", 2, 1000);
    checkOutput("read1_len",    last_len,         226);
    checkOutput("read1_rises",  last_rises,       56);
    checkOutput("read1_cmd",    last_mosi[55:48], 8'hE8);
    checkOutput("read1_zeros",  last_mosi[47:0],  48'h0);
    checkOutput("read1_valid",  valid_cnt,        1);
    checkOutput("read1_vtime",  64'(valid_cyc - rise_cyc), 64'd0);
    checkOutput("read1_out_x",  out_x,            16'h1234);
    checkOutput("read1_out_y",  out_y,            16'hFFFF);
    checkOutput("read1_out_z",  out_z,            16'h8000);

    // Second read, with frame 01 00 00 7F CD AB.
    sensor_data = 48'h0100007FCDAB;
    applyStimulus("read2_done", 3, 1000);
    checkOutput("read2_spacing", 64'(last_fall - prev_fall), 64'd400);
    checkOutput("read2_rises",   last_rises,       56);
    checkOutput("read2_cmd",     last_mosi[55:48], 8'hE8);
    checkOutput("read2_valid",   valid_cnt,        2);
    checkOutput("read2_out_x",   out_x,            16'h0001);
    checkOutput("read2_out_y",   out_y,            16'h7F00);
    checkOutput("read2_out_z",   out_z,            16'hABCD);

    // Abort the third read around bit 30.
    n_wait = 0;
    while (!(txn_count == 3 && !spi_cs_n && cur_rises >= 30) && n_wait < 1000) begin
      @(negedge clk);
      #1;
      n_wait++;
    end
    checkOutput("abort_reached", 64'(n_wait < 1000), 64'd1);
    saved_valid = valid_cnt;
    rst = 1'b1;
    #1;
    checkOutput("abort_cs_n",  spi_cs_n, 1'b1);
    checkOutput("abort_sck",   spi_sck,  1'b1);
    checkOutput("abort_mosi",  spi_mosi, 1'b0);
    checkOutput("abort_out_x", out_x,    16'h0000);
    checkOutput("abort_out_y", out_y,    16'h0000);
    checkOutput("abort_out_z", out_z,    16'h0000);
    checkOutput("abort_busy",  busy,     1'b0);
    checkOutput("abort_valid", valid,    1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // After release, the configuration write is repeated first.
    applyStimulus("reinit_done", 4, 200);
    checkOutput("reinit_mosi",  last_mosi[15:0], 16'h2077);
    checkOutput("reinit_rises", last_rises,      16);
    checkOutput("reinit_len",   last_len,        66);
    checkOutput("reinit_valid", valid_cnt,       saved_valid);

    checkOutput("invariants", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
